dfc_param: RTL

DFC_PARAM -- requirements
Module: dfc_param

---
 rtl/dfc_param.sv | 114 +++++++++++
 1 files changed

// File: rtl/dfc_param.sv
// Dual-half buffer: loads DEPTH samples, then streams pairwise sums/differences
// of the lower and upper halves in FIFO or LIFO order under valid/ready flow control.
module dfc_param #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] datain,
    input  logic [1:0]        cmd,
    input  logic              op,
    input  logic              cmd_valid,
    input  logic              out_ready,
    output logic [DATA_W:0]   dataout,
    output logic              output_valid,
    output logic              out_last,
    output logic              busy
);

    localparam int unsigned HALF = DEPTH / 2;
    localparam int unsigned LW   = $clog2(DEPTH);
    localparam int unsigned BW   = (HALF > 1) ? $clog2(HALF) : 1;

    typedef enum logic [2:0] {StIdle, StLoad, StClear, StCompute, StOut} state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] buf_q [DEPTH];
    logic [DATA_W:0]   r_q   [HALF];
    logic [LW-1:0]     load_cnt_q;
    logic [BW-1:0]     beat_q;
    logic              op_q;
    logic              lifo_q;
    logic              accept;
    logic              last_beat;
    logic              load_last;
    logic [BW-1:0]     rd_idx;

    assign accept    = (state_q == StIdle) && cmd_valid;
    assign last_beat = (beat_q == BW'(HALF - 1));
    assign load_last = (load_cnt_q == LW'(DEPTH - 1));
    assign rd_idx    = lifo_q ? (BW'(HALF - 1) - beat_q) : beat_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    case (cmd)
                        2'd0:    state_d = StLoad;
                        2'd3:    state_d = StClear;
                        default: state_d = StCompute;
                    endcase
                end
            end
            StLoad:    if (load_last) state_d = StIdle;
            StClear:   state_d = StIdle;
            StCompute: state_d = StOut;
            StOut:     if (out_ready && last_beat) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_comb begin
        busy         = (state_q != StIdle);
        output_valid = (state_q == StOut);
        dataout      = '0;
        out_last     = 1'b0;
        if (output_valid) begin
            dataout  = r_q[rd_idx];
            out_last = last_beat;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            load_cnt_q <= '0;
            beat_q     <= '0;
            op_q       <= 1'b0;
            lifo_q     <= 1'b0;
            for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
            for (int i = 0; i < HALF; i++) r_q[i] <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q       <= op;
                lifo_q     <= (cmd == 2'd2);
                load_cnt_q <= '0;
                beat_q     <= '0;
            end
            case (state_q)
                StLoad: begin
                    buf_q[load_cnt_q] <= datain;
                    load_cnt_q        <= load_last ? '0 : load_cnt_q + 1'b1;
                end
                StClear: begin
                    for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
                end
                StCompute: begin
                    // Zero-extend both operands so add keeps the carry and subtract wraps mod 2^(W+1)
                    for (int i = 0; i < HALF; i++) begin
                        r_q[i] <= op_q ? ({1'b0, buf_q[i]} - {1'b0, buf_q[i+HALF]})
                                       : ({1'b0, buf_q[i]} + {1'b0, buf_q[i+HALF]});
                    end
                end
                StOut: begin
                    if (out_ready) beat_q <= last_beat ? '0 : beat_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
